// File: rtl/cpu_mcu_bus_bridge_pkg.sv
// Shared types and window constants for the Z80-to-MCU bus bridge.
// The default window constants are also used by the board address decoder.
package cpu_mcu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STROBE = 2'd1,
    HOLD   = 2'd2
  } bridge_state_t;

  localparam logic [15:0] MCU_BASE_ADDR = 16'hEF00;
  localparam logic [15:0] MCU_ADDR_MASK = 16'hFF00;

  // True when the address falls inside the masked window.
  function automatic logic addr_in_window(input logic [15:0] addr,
                                          input logic [15:0] base,
                                          input logic [15:0] mask);
    return ((addr & mask) == base);
  endfunction

endpackage

// File: rtl/cpu_mcu_bus_bridge_if.sv
// Z80 bus / MCU bus signal bundle for the bus bridge.
// master = CPU + MCU side (drives the bus inputs), slave = the bridge.
interface cpu_mcu_bus_bridge_if;

  logic [15:0] ADDR;
  logic        MREQ_AL;
  logic        RD_AL;
  logic        WR_AL;
  logic [7:0]  DATA_IN;
  logic [3:0]  MCU_DB;
  logic        IN3_AL;
  logic        WAIT_AL;
  logic [7:0]  DATA_OUT;
  logic        DATA_OE;
  logic [3:0]  CMD_OUT;

  modport master (
    output ADDR, MREQ_AL, RD_AL, WR_AL, DATA_IN, MCU_DB,
    input  IN3_AL, WAIT_AL, DATA_OUT, DATA_OE, CMD_OUT
  );

  modport slave (
    input  ADDR, MREQ_AL, RD_AL, WR_AL, DATA_IN, MCU_DB,
    output IN3_AL, WAIT_AL, DATA_OUT, DATA_OE, CMD_OUT
  );

endinterface

// File: rtl/cpu_mcu_bus_bridge.sv
// Z80-side bridge to the custom MCU: one IN3_AL strobe per read access with
// WAIT held for the strobe, nibble capture on the last strobe edge, and a
// one-shot command latch for writes into the same window.
module cpu_mcu_bus_bridge
  import cpu_mcu_bus_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR     = MCU_BASE_ADDR,
  parameter logic [15:0] ADDR_MASK     = MCU_ADDR_MASK,
  parameter int          STROBE_CYCLES = 2,
  parameter logic [3:0]  UPPER_NIBBLE  = 4'h0
) (
  input  logic                 CPU_CLOCK,
  input  logic                 RESET_AL,
  cpu_mcu_bus_bridge_if.slave  bus
);

  localparam logic [3:0] STROBE_LAST = STROBE_CYCLES[3:0];

  bridge_state_t state_r;
  logic [3:0]    cnt_r;
  logic          wr_done_r;
  logic          in3_r;
  logic          wait_r;
  logic          oe_r;
  logic [7:0]    dout_r;
  logic [3:0]    cmd_r;

  logic addr_hit_s;
  logic rd_hit_s;
  logic wr_hit_s;
  logic data_in_unused_s;

  assign addr_hit_s = addr_in_window(bus.ADDR, BASE_ADDR, ADDR_MASK);
  assign rd_hit_s   = !bus.MREQ_AL && !bus.RD_AL && addr_hit_s;
  assign wr_hit_s   = !bus.MREQ_AL && !bus.WR_AL && addr_hit_s;

  // Only the low nibble of the write data carries a command.
  assign data_in_unused_s = ^bus.DATA_IN[7:4];

  // Bridge FSM: strobe sequencing, nibble capture and one-shot write latch.
  always_ff @(posedge CPU_CLOCK or negedge RESET_AL) begin
    if (!RESET_AL) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      wr_done_r <= 1'b0;
      in3_r     <= 1'b1;
      wait_r    <= 1'b1;
      oe_r      <= 1'b0;
      dout_r    <= 8'h00;
      cmd_r     <= 4'h0;
    end else begin
      // The write-done flag re-arms as soon as the write access ends.
      if (!wr_hit_s) begin
        wr_done_r <= 1'b0;
      end
      case (state_r)
        IDLE: begin
          if (rd_hit_s) begin
            // Read wins over a simultaneous write; no command is latched.
            state_r <= STROBE;
            in3_r   <= 1'b0;
            wait_r  <= 1'b0;
            cnt_r   <= 4'd1;
          end else if (wr_hit_s && !wr_done_r) begin
            cmd_r     <= bus.DATA_IN[3:0];
            wr_done_r <= 1'b1;
          end
        end
        STROBE: begin
          if (!rd_hit_s) begin
            // Access withdrawn mid-strobe: release the MCU, keep old data.
            state_r <= IDLE;
            in3_r   <= 1'b1;
            wait_r  <= 1'b1;
            cnt_r   <= 4'd0;
          end else if (cnt_r == STROBE_LAST) begin
            // Last strobe edge: MCU_DB already holds the post-increment value.
            state_r <= HOLD;
            dout_r  <= {UPPER_NIBBLE, bus.MCU_DB};
            in3_r   <= 1'b1;
            wait_r  <= 1'b1;
            oe_r    <= 1'b1;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        HOLD: begin
          if (bus.RD_AL || bus.MREQ_AL) begin
            state_r <= IDLE;
            oe_r    <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= 4'd0;
          in3_r   <= 1'b1;
          wait_r  <= 1'b1;
          oe_r    <= 1'b0;
        end
      endcase
    end
  end

  assign bus.IN3_AL   = in3_r;
  assign bus.WAIT_AL  = wait_r;
  assign bus.DATA_OE  = oe_r;
  assign bus.DATA_OUT = dout_r;
  assign bus.CMD_OUT  = cmd_r;

endmodule

// File: tb/tb_cpu_mcu_bus_bridge.sv
// Self-checking bench for cpu_mcu_bus_bridge with an MCU dummy whose
// nibble counter advances on each IN3_AL falling edge.
module tb_cpu_mcu_bus_bridge;

  localparam int         S     = 2;
  localparam logic [3:0] UPPER = 4'h0;

  logic clk = 1'b0;
  logic rst_n;

  cpu_mcu_bus_bridge_if bus ();

  cpu_mcu_bus_bridge #(
    .BASE_ADDR     (16'hEF00),
    .ADDR_MASK     (16'hFF00),
    .STROBE_CYCLES (S),
    .UPPER_NIBBLE  (UPPER)
  ) dut (
    .CPU_CLOCK (clk),
    .RESET_AL  (rst_n),
    .bus       (bus.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // MCU dummy: counter advances on IN3_AL falling.
  logic [3:0] mcu_cnt = 4'h0;
  int         fall_cnt = 0;
  assign bus.MCU_DB = mcu_cnt;

  always @(negedge bus.IN3_AL) begin
    mcu_cnt  = mcu_cnt + 4'h1;
    fall_cnt = fall_cnt + 1;
  end

  // Bench-side expectations
  logic [7:0] sb_q[$];
  logic [3:0] exp_nib   = 4'h0;
  logic [7:0] last_dout = 8'h00;
  logic [3:0] last_cmd  = 4'h0;
  logic [7:0] exp_d;
  logic       oe_q = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  // Scoreboard monitor: compare read data on each DATA_OE rising.
  always @(negedge clk) begin
    if (bus.DATA_OE === 1'b1 && oe_q === 1'b0) begin
      check_eq("sb_nonempty", {31'd0, sb_q.size() != 0}, 32'd1);
      if (sb_q.size() != 0) begin
        exp_d = sb_q.pop_front();
        check_eq("rd_data", {24'd0, bus.DATA_OUT}, {24'd0, exp_d});
      end
    end
    oe_q = bus.DATA_OE;
  end

  task automatic read_access(input logic [15:0] a, input bit hit, input bit also_wr);
    int f0;
    f0 = fall_cnt;
    if (hit) begin
      exp_nib = exp_nib + 4'h1;
      sb_q.push_back({UPPER, exp_nib});
    end
    @(negedge clk);
    bus.ADDR    = a;
    bus.DATA_IN = 8'h09;
    bus.MREQ_AL = 1'b0;
    bus.RD_AL   = 1'b0;
    bus.WR_AL   = !also_wr;
    for (int k = 0; k < S; k++) begin
      @(negedge clk);
      check_eq("in3_strobe", {31'd0, bus.IN3_AL}, hit ? 32'd0 : 32'd1);
      check_eq("wait_strobe", {31'd0, bus.WAIT_AL}, hit ? 32'd0 : 32'd1);
      check_eq("oe_strobe", {31'd0, bus.DATA_OE}, 32'd0);
    end
    @(negedge clk);
    check_eq("in3_end", {31'd0, bus.IN3_AL}, 32'd1);
    check_eq("wait_end", {31'd0, bus.WAIT_AL}, 32'd1);
    check_eq("oe_valid", {31'd0, bus.DATA_OE}, hit ? 32'd1 : 32'd0);
    if (hit) begin
      last_dout = {UPPER, exp_nib};
    end
    bus.MREQ_AL = 1'b1;
    bus.RD_AL   = 1'b1;
    bus.WR_AL   = 1'b1;
    @(negedge clk);
    check_eq("oe_release", {31'd0, bus.DATA_OE}, 32'd0);
    check_eq("dout_retain", {24'd0, bus.DATA_OUT}, {24'd0, last_dout});
    check_eq("cmd_no_change", {28'd0, bus.CMD_OUT}, {28'd0, last_cmd});
    check_eq("strobe_count", 32'(fall_cnt - f0), hit ? 32'd1 : 32'd0);
  endtask

  task automatic write_access(input logic [15:0] a, input logic [7:0] d1, input logic [7:0] d2);
    @(negedge clk);
    bus.ADDR    = a;
    bus.DATA_IN = d1;
    bus.MREQ_AL = 1'b0;
    bus.WR_AL   = 1'b0;
    last_cmd    = d1[3:0];
    @(negedge clk);
    check_eq("cmd_first_edge", {28'd0, bus.CMD_OUT}, {28'd0, last_cmd});
    // Data changes mid-access must not be re-latched.
    bus.DATA_IN = d2;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check_eq("cmd_once", {28'd0, bus.CMD_OUT}, {28'd0, last_cmd});
      check_eq("in3_on_write", {31'd0, bus.IN3_AL}, 32'd1);
    end
    bus.MREQ_AL = 1'b1;
    bus.WR_AL   = 1'b1;
    @(negedge clk);
    check_eq("cmd_after", {28'd0, bus.CMD_OUT}, {28'd0, last_cmd});
  endtask

  initial begin
    int f0;
    bus.ADDR    = 16'h0000;
    bus.MREQ_AL = 1'b1;
    bus.RD_AL   = 1'b1;
    bus.WR_AL   = 1'b1;
    bus.DATA_IN = 8'h00;
    rst_n       = 1'b0;
    #12;
    check_eq("rst_in3", {31'd0, bus.IN3_AL}, 32'd1);
    check_eq("rst_wait", {31'd0, bus.WAIT_AL}, 32'd1);
    check_eq("rst_oe", {31'd0, bus.DATA_OE}, 32'd0);
    check_eq("rst_dout", {24'd0, bus.DATA_OUT}, 32'd0);
    check_eq("rst_cmd", {28'd0, bus.CMD_OUT}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // 17 reads across the window: 01..0F, 00, 01
    for (int i = 0; i < 17; i++) begin
      read_access(16'hEF00 + 16'(i), 1'b1, 1'b0);
    end

    // Outside the window
    read_access(16'hEE00, 1'b0, 1'b0);
    read_access(16'hF000, 1'b0, 1'b0);

    // Abort after one strobe cycle
    f0 = fall_cnt;
    exp_nib = exp_nib + 4'h1;
    @(negedge clk);
    bus.ADDR    = 16'hEF40;
    bus.MREQ_AL = 1'b0;
    bus.RD_AL   = 1'b0;
    @(negedge clk);
    check_eq("abort_in3_low", {31'd0, bus.IN3_AL}, 32'd0);
    bus.RD_AL   = 1'b1;
    bus.MREQ_AL = 1'b1;
    @(negedge clk);
    check_eq("abort_in3", {31'd0, bus.IN3_AL}, 32'd1);
    check_eq("abort_wait", {31'd0, bus.WAIT_AL}, 32'd1);
    check_eq("abort_oe", {31'd0, bus.DATA_OE}, 32'd0);
    check_eq("abort_dout", {24'd0, bus.DATA_OUT}, {24'd0, last_dout});
    @(negedge clk);
    check_eq("abort_oe_late", {31'd0, bus.DATA_OE}, 32'd0);
    check_eq("abort_strobes", 32'(fall_cnt - f0), 32'd1);

    // Writes
    write_access(16'hEF10, 8'hA5, 8'hF7);
    write_access(16'hEF10, 8'h3C, 8'h11);

    // Read with WR also low: read wins, no command latch
    read_access(16'hEF20, 1'b1, 1'b1);

    // Reset pulse mid-strobe
    exp_nib = exp_nib + 4'h1;
    @(negedge clk);
    bus.ADDR    = 16'hEF00;
    bus.MREQ_AL = 1'b0;
    bus.RD_AL   = 1'b0;
    @(negedge clk);
    check_eq("pre_rst_in3", {31'd0, bus.IN3_AL}, 32'd0);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_in3", {31'd0, bus.IN3_AL}, 32'd1);
    check_eq("async_rst_wait", {31'd0, bus.WAIT_AL}, 32'd1);
    check_eq("async_rst_oe", {31'd0, bus.DATA_OE}, 32'd0);
    check_eq("async_rst_dout", {24'd0, bus.DATA_OUT}, 32'd0);
    check_eq("async_rst_cmd", {28'd0, bus.CMD_OUT}, 32'd0);
    bus.MREQ_AL = 1'b1;
    bus.RD_AL   = 1'b1;
    #1;
    rst_n     = 1'b1;
    last_dout = 8'h00;
    last_cmd  = 4'h0;
    @(negedge clk);
    check_eq("post_rst_in3", {31'd0, bus.IN3_AL}, 32'd1);
    check_eq("post_rst_oe", {31'd0, bus.DATA_OE}, 32'd0);

    // Recovery read
    read_access(16'hEFFF, 1'b1, 1'b0);

    check_eq("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/cpu_mcu_bus_bridge.md
# cpu_mcu_bus_bridge

Z80-side bus bridge for the custom microcomputer (MB8841 stand-in) on the CPU board. It decodes game-CPU memory accesses to the MCU window and generates one active-low `IN3_AL` read strobe per read access. It captures the 4-bit MCU data bus, holds the CPU in WAIT while the strobe is active, and presents the nibble on the CPU data bus until the access ends. Writes to the same window latch a 4-bit command nibble for the MCU side.

## Interface
Parameters:
- `BASE_ADDR`, 16'hEF00: base of the MCU window.
- `ADDR_MASK`, 16'hFF00: a hit is `(ADDR & ADDR_MASK) == BASE_ADDR`.
- `STROBE_CYCLES`, 2: number of `CPU_CLOCK` cycles `IN3_AL` is held low. Legal range is 1–15.
- `UPPER_NIBBLE`, 4'h0: value driven on `DATA_OUT[7:4]` during a read.

Ports:
- `CPU_CLOCK`, in, 1: the only clock. All logic is on its rising edge.
- `RESET_AL`, in, 1: asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `ADDR`, in, 16: Z80 address bus.
- `MREQ_AL`, in, 1: Z80 memory request, active low.
- `RD_AL`, in, 1: Z80 read, active low.
- `WR_AL`, in, 1: Z80 write, active low.
- `DATA_IN`, in, 8: Z80 write data.
- `MCU_DB`, in, 4: MCU data bus (DB3..DB0), valid while `IN3_AL` is low.
- `IN3_AL`, out, 1: MCU read strobe, active low.
- `WAIT_AL`, out, 1: Z80 WAIT, active low.
- `DATA_OUT`, out, 8: read data returned to the CPU.
- `DATA_OE`, out, 1: high when the bridge drives the CPU data bus.
- `CMD_OUT`, out, 4: last command nibble written.

## Operation
- Definitions:
  - `rd_hit = !MREQ_AL && !RD_AL && addr_hit`
  - `wr_hit = !MREQ_AL && !WR_AL && addr_hit`
- Reset values (asynchronous, while `RESET_AL` = 0):
  - State = IDLE.
  - `IN3_AL` = 1, `WAIT_AL` = 1, `DATA_OE` = 0.
  - `DATA_OUT` = 8'h00, `CMD_OUT` = 4'h0.
  - Strobe counter = 0, write-done flag = 0.
- FSM states: IDLE, STROBE, HOLD.
  - IDLE → STROBE when `rd_hit`. On that edge:
    - `IN3_AL` ← 0, `WAIT_AL` ← 0, counter ← 1.
  - STROBE, while counter < `STROBE_CYCLES` and `rd_hit` is still true: counter increments; outputs unchanged.
  - STROBE → HOLD when counter == `STROBE_CYCLES` and `rd_hit` is true. On that edge:
    - `DATA_OUT` ← {`UPPER_NIBBLE`, `MCU_DB`}.
    - `IN3_AL` ← 1, `WAIT_AL` ← 1, `DATA_OE` ← 1.
  - STROBE → IDLE (abort) when `rd_hit` is false:
    - `IN3_AL` ← 1, `WAIT_AL` ← 1, `DATA_OE` stays 0.
    - `DATA_OUT` is unchanged.
  - HOLD → IDLE when `RD_AL` = 1 or `MREQ_AL` = 1. On that edge `DATA_OE` ← 0; `DATA_OUT` is retained.
- A single read access generates exactly one strobe. A new strobe requires passing through IDLE with `rd_hit` false for at least one cycle.
- Writes:
  - In IDLE, `wr_hit` with write-done = 0 latches `CMD_OUT` ← `DATA_IN[3:0]` and sets write-done.
  - Write-done clears when `wr_hit` is false.
  - So each write access produces exactly one latch. Writes are ignored outside IDLE.
- Simultaneous `rd_hit` and `wr_hit` (illegal on a Z80): the read takes priority and no write is latched.
- Addresses outside the window: no outputs change.

## Timing
- Read latency from the edge that samples `rd_hit`:
  - `IN3_AL` is low for exactly `STROBE_CYCLES` cycles, starting the next cycle.
  - Data becomes valid and `DATA_OE` = 1 the cycle after the strobe ends.
  - Total: `STROBE_CYCLES` + 1 edges.
- `WAIT_AL` is coincident with `IN3_AL` low, cycle for cycle.
- `MCU_DB` is sampled on the last rising edge of the strobe, while `IN3_AL` is still low. The MCU counter advances on `IN3_AL` falling, so the post-increment value is captured.
- `DATA_OE` falls one edge after `RD_AL` or `MREQ_AL` rises.
- A write latches on the first edge `wr_hit` is seen; `CMD_OUT` is updated in the same cycle.
- Asserting reset mid-strobe forces `IN3_AL` = 1 immediately (asynchronously). No capture occurs.

## Structure
- Package `cpu_mcu_bus_pkg`: enum `bridge_state_t` {IDLE, STROBE, HOLD}, plus default `BASE_ADDR`/`ADDR_MASK` constants shared with the board address decoder.
- Single module. No sub-module is needed; the address compare is one line.
- `STROBE_CYCLES` counter width is 4 bits.

## Test plan
- Reset, then a read of 16'hEF00 with `STROBE_CYCLES` = 2, using the MCU dummy as the model: `IN3_AL` is low for 2 cycles and `WAIT_AL` low for the same 2 cycles. `DATA_OUT` = 8'h01 and `DATA_OE` = 1 on cycle 3; `DATA_OE` = 0 one edge after `RD_AL` rises.
- 17 back-to-back reads: data sequence 01, 02, …, 0F, 00, 01 (4-bit wrap). Exactly one `IN3_AL` falling edge per read.
- Read of 16'hEE00 and 16'hF000: `IN3_AL`, `WAIT_AL` and `DATA_OE` never change.
- `RD_AL` deasserted after 1 strobe cycle: `IN3_AL` and `WAIT_AL` return to 1 on the next edge, `DATA_OE` stays 0, and `DATA_OUT` keeps its previous value.
- Write 8'hA5 to 16'hEF10 with `WR_AL` held low for 3 cycles: `CMD_OUT` = 4'h5, latched once. A following write of 8'h3C gives `CMD_OUT` = 4'hC.
- `RESET_AL` pulsed low mid-strobe between clock edges: `IN3_AL` goes to 1 at once, state returns to IDLE, and all outputs take their reset values.
